mmm_sequencer: RTL

- Multi-cycle controller for the matrix-multiply unit (MMM) that starts execution in the EX stage.
- When an MMM instruction is in EX, it holds the pipeline through `mmm_stall` and walks i/j/k loop counters over a DIM×DIM tile.
- Each cycle it issues A/B scratchpad reads, drives the MAC clear/enable strobes, and writes each finished C element back.
- It releases the pipeline for exactly one cycle so the MMM instruction retires.

---
 rtl/mmm_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mmm_sequencer.sv
// Matrix-multiply loop controller. It holds the pipeline while it walks i/j/k over a DIM x DIM tile.
// Build option MMM_TRANSPOSE_B_EN: the B tile is stored transposed (B address = b_base + j*DIM + k).
module mmm_sequencer #(
   parameter int DIM    = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_EX,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] c_base,
   output logic              mmm_stall,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic              mac_clear,
   output logic              mac_en,
   output logic              c_wr_en,
   output logic [ADDR_W-1:0] c_wr_addr,
   output logic              busy,
   output logic              done
);

   // state | meaning
   // IDLE  | waiting for start_EX
   // LOAD  | issue A/B read for (i,j,k)
   // DRAIN | last product of C(i,j) accumulates
   // WRITE | store C(i,j), advance j/i
   // DONE  | pipeline released for one cycle

   localparam int                CW     = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CW-1:0]     LAST   = CW'(DIM - 1);
   localparam logic [CW-1:0]     ONE    = CW'(1);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DIM);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, WRITE, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] a_q, b_q, c_q;
   logic [CW-1:0]     i_q, j_q, k_q;
   logic [ADDR_W-1:0] i_off, k_off;
   logic [ADDR_W-1:0] b_off;
   logic              mac_en_q, mac_clear_q;
   logic              i_last, j_last, k_last;

   assign i_last = (i_q == LAST);
   assign j_last = (j_q == LAST);
   assign k_last = (k_q == LAST);

`ifdef MMM_TRANSPOSE_B_EN
   logic [ADDR_W-1:0] j_off;

   always_ff @(posedge clk) begin
      if (!reset) begin
         j_off <= '0;
      end else if (state == IDLE && start_EX) begin
         j_off <= '0;
      end else if (state == WRITE) begin
         j_off <= j_last ? '0 : j_off + STRIDE;
      end
   end

   assign b_off = j_off + ADDR_W'(k_q);
`else
   assign b_off = k_off + ADDR_W'(j_q);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         i_off       <= '0;
         k_off       <= '0;
         mac_en_q    <= 1'b0;
         mac_clear_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         // read data returns one cycle after rd_en, so the MAC strobes trail it by a cycle
         mac_en_q    <= rd_en;
         mac_clear_q <= rd_en && (k_q == '0);
         case (state)
            IDLE: begin
               if (start_EX) begin
                  a_q   <= a_base;
                  b_q   <= b_base;
                  c_q   <= c_base;
                  i_q   <= '0;
                  j_q   <= '0;
                  k_q   <= '0;
                  i_off <= '0;
                  k_off <= '0;
               end
            end
            LOAD: begin
               if (k_last) begin
                  k_q   <= '0;
                  k_off <= '0;
               end else begin
                  k_q   <= k_q + ONE;
                  k_off <= k_off + STRIDE;
               end
            end
            WRITE: begin
               if (j_last) begin
                  j_q <= '0;
                  if (i_last) begin
                     i_q   <= '0;
                     i_off <= '0;
                  end else begin
                     i_q   <= i_q + ONE;
                     i_off <= i_off + STRIDE;
                  end
               end else begin
                  j_q <= j_q + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      mmm_stall = 1'b0;
      rd_en     = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      c_wr_en   = 1'b0;
      c_wr_addr = '0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            // combinational on start_EX so the start cycle itself holds the pipeline
            mmm_stall = start_EX;
            if (start_EX) state_nxt = LOAD;
         end
         LOAD: begin
            mmm_stall = 1'b1;
            rd_en     = 1'b1;
            rd_addr_a = a_q + i_off + ADDR_W'(k_q);
            rd_addr_b = b_q + b_off;
            if (k_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            mmm_stall = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            mmm_stall = 1'b1;
            c_wr_en   = 1'b1;
            c_wr_addr = c_q + i_off + ADDR_W'(j_q);
            state_nxt = (i_last && j_last) ? DONE : LOAD;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mac_en    = mac_en_q;
   assign mac_clear = mac_clear_q;

endmodule
